// File: rtl/btn_pkg.sv
// Shared state type and default timing constants for push-button conditioners.
// Every button instance in the design uses the same values.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMING = 3'd1,
    HELD   = 3'd2,
    REPEAT = 3'd3,
    DISARM = 3'd4
  } btn_state_t;

  localparam int DEBOUNCE_12MS_100MHZ       = 1_200_000;
  localparam int REPEAT_DELAY_500MS_100MHZ  = 50_000_000;
  localparam int REPEAT_PERIOD_100MS_100MHZ = 10_000_000;
  localparam int SYNC_STAGES_DEFAULT        = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Flip-flop chain that brings an asynchronous input into the clk domain.
// The reset value is a parameter, so an input can be parked in its inactive level.
module btn_sync
  import btn_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the chain; the oldest bit is the synchronised output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Conditioner for one mechanical push-button. It produces a debounced level, one-cycle
// press and release strobes, and optional auto-repeat strobes while the button is held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_12MS_100MHZ,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_100MHZ,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS_100MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W  = max_int(1, $clog2(DEBOUNCE_CYCLES));
  localparam int RCNT_W = max_int(1, $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)));

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);

  logic              w_btn_pressed;
  logic              w_p;
  btn_state_t        r_state;
  btn_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [RCNT_W-1:0] r_rcnt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic              r_level;
  logic              w_level_nxt;
  logic              r_press;
  logic              w_press_nxt;
  logic              r_release;
  logic              w_release_nxt;
  logic              r_repeat;
  logic              w_repeat_nxt;

  // Fix the pin polarity before synchronising, so a reset chain reads as "not pressed".
  assign w_btn_pressed = BTN_ACTIVE_LOW ? ~btn : btn;

  btn_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (w_btn_pressed),
    .o_q  (w_p)
  );

  // Next-state, counter and strobe decode; only the synchronised level and counters steer it.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rcnt_nxt    = r_rcnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_p) begin
          w_state_nxt = ARMING;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ARMING: begin
        if (!w_p) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_rcnt_nxt  = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!w_p) begin
          w_state_nxt = DISARM;
          w_cnt_nxt   = '0;
          w_rcnt_nxt  = '0;
        end else if (REPEAT_EN) begin
          if (r_rcnt == DELAY_LAST) begin
            w_state_nxt  = REPEAT;
            w_rcnt_nxt   = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + RCNT_ONE;
          end
        end else begin
          w_rcnt_nxt = '0;
        end
      end
      REPEAT: begin
        if (!w_p) begin
          w_state_nxt = DISARM;
          w_cnt_nxt   = '0;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == PERIOD_LAST) begin
          w_rcnt_nxt   = '0;
          w_repeat_nxt = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + RCNT_ONE;
        end
      end
      DISARM: begin
        // A bounce on release goes back to HELD, and the repeat timing restarts from the full delay.
        if (w_p) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_rcnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_rcnt_nxt  = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios with literal expectations, then random bursts.
// A run-length model of the debounce rules is compared with the DUT on every cycle.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  logic clk;
  logic rst_n;
  logic btn;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [SYNC-1:0] hist;
  logic m_level, m_press, m_rel, m_rep;
  int   run, held;

  int press_cnt = 0, rel_cnt = 0, press_cyc = 0, rel_cyc = 0;
  int rep_q[$];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .BTN_ACTIVE_LOW (1'b1),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    hist = '0; m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    run = 0; held = 0;
  endtask

  // A level change is accepted after DEB+1 consecutive disagreeing synchronised samples.
  // Repeat strobes fall at RDLY, RDLY+RPER, ... cycles of undisturbed hold.
  task automatic m_step();
    logic p;
    p = hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ~btn;
    m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    if (p != m_level) begin
      run++;
      if (run == DEB + 1) begin
        run = 0;
        if (!m_level) begin
          m_level = 1'b1; m_press = 1'b1; held = 0;
        end else begin
          m_level = 1'b0; m_rel = 1'b1;
        end
      end
    end else begin
      if (m_level && run == 0) begin
        held++;
        if (held >= RDLY && (held - RDLY) % RPER == 0) m_rep = 1'b1;
      end else begin
        held = 0;
      end
      run = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_bit("btn_level", btn_level, m_level);
      check_bit("press_pulse", press_pulse, m_press);
      check_bit("release_pulse", release_pulse, m_rel);
      check_bit("repeat_pulse", repeat_pulse, m_rep);
      if (press_pulse === 1'b1) begin press_cnt++; press_cyc = cyc; end
      if (release_pulse === 1'b1) begin rel_cnt++; rel_cyc = cyc; end
      if (repeat_pulse === 1'b1) rep_q.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int c0, c2, c3, c4, first, dur;
    btn = 1'b1;
    rst_n = 1'b0;
    step(3);
    check_bit("reset_level", btn_level, 1'b0);
    check_bit("reset_press", press_pulse, 1'b0);
    rst_n = 1'b1;
    step(3);

    // Clean press: the strobe lands 6 edges after the first sampling edge.
    c0 = cyc; rep_q.delete(); btn = 1'b0;
    step(12);
    check_int("press_count", press_cnt, 1);
    check_int("press_latency", press_cyc - (c0 + 1), 6);
    check_bit("level_after_press", btn_level, 1'b1);

    // Auto-repeat: 6 strobes by press+25, the first one at +10.
    step(20);
    check_int("repeat_count", rep_q.size(), 6);
    first = (rep_q.size() > 0) ? rep_q[0] : -1;
    check_int("first_repeat_offset", first - press_cyc, 10);

    // Release bounce: no release, and the repeat timing restarts 10 cycles after HELD resumes.
    c2 = cyc; rep_q.delete(); btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(20);
    check_int("bounce_release_count", rel_cnt, 0);
    check_bit("bounce_level", btn_level, 1'b1);
    first = -1;
    foreach (rep_q[i]) if (first < 0 && rep_q[i] > c2 + 5) first = rep_q[i];
    check_int("repeat_after_bounce", first - c2, 15);

    // Clean release.
    c3 = cyc; btn = 1'b1;
    step(12);
    check_int("release_count", rel_cnt, 1);
    check_int("release_latency", rel_cyc - (c3 + 1), 6);
    check_bit("level_after_release", btn_level, 1'b0);

    // Press bounce: low 2 cycles, high 1, low 2, then high. No press may be accepted.
    btn = 1'b0; step(2); btn = 1'b1; step(1); btn = 1'b0; step(2); btn = 1'b1;
    step(10);
    check_int("bounce_press_count", press_cnt, 1);
    check_bit("bounce_press_level", btn_level, 1'b0);

    // Reset mid-hold: outputs clear at once, no release strobe, then a fresh press.
    btn = 1'b0;
    step(15);
    check_int("hold_press_count", press_cnt, 2);
    check_bit("held_before_reset", btn_level, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("async_level", btn_level, 1'b0);
    check_bit("async_press", press_pulse, 1'b0);
    check_bit("async_release", release_pulse, 1'b0);
    check_bit("async_repeat", repeat_pulse, 1'b0);
    step(3);
    rst_n = 1'b1;
    c4 = cyc;
    step(12);
    check_int("repress_count", press_cnt, 3);
    check_int("repress_latency", press_cyc - (c4 + 1), 6);
    check_int("no_release_on_reset", rel_cnt, 1);

    // Random bursts with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      btn = ~btn;
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 40) : $urandom_range(1, 6);
      step(dur);
    end
    btn = 1'b1;
    step(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
